// File: rtl/rgb2ycbcr_pkg.sv
// Shared constants for the streaming RGB -> YCbCr converter.
//   - BT.601 / JFIF coefficients as reals, plus a helper that turns them
//     into rounded fixed-point integers for any fractional width.
//   - Mode encodings carried with each block.
package rgb2ycbcr_pkg;

  localparam real C_YR  =  0.299;
  localparam real C_YG  =  0.587;
  localparam real C_YB  =  0.114;
  localparam real C_CBR = -0.168736;
  localparam real C_CBG = -0.331264;
  localparam real C_CBB =  0.5;
  localparam real C_CRR =  0.5;
  localparam real C_CRG = -0.418688;
  localparam real C_CRB = -0.081312;

  localparam logic MODE_JFIF    = 1'b0;
  localparam logic MODE_CENTRED = 1'b1;

  // round(c * 2^frac_bits), ties away from zero
  function automatic int coef_fixed(input real c, input int unsigned frac_bits);
    real s;
    s = c;
    for (int unsigned i = 0; i < frac_bits; i++) begin
      s = s * 2.0;
    end
    if (s >= 0.0) begin
      return $rtoi(s + 0.5);
    end else begin
      return -$rtoi(0.5 - s);
    end
  endfunction

endpackage

// File: rtl/rgb2ycbcr_lane_pipe.sv
// One-pixel conversion lane.
//   Stage 1 (registered here): nine sample x coefficient products + mode.
//   Stage 2 (combinational outputs): row sums plus mode-dependent offset;
//   the parent registers these into its assembly buffer.
// Ports:
//   clk, rst        clock / synchronous active-high reset
//   i_en            pipeline advance enable
//   i_valid, i_mode beat valid and block mode for this beat
//   i_r/i_g/i_b     unsigned samples
//   o_valid, o_mode stage-1 valid and mode
//   o_y/o_cb/o_cr   converted pixel, two's complement fixed point
module rgb2ycbcr_lane_pipe
  import rgb2ycbcr_pkg::*;
#(
  parameter int unsigned fixed_point_length = 32,
  parameter int unsigned frac_bits          = 16,
  parameter int unsigned input_width        = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_en,
  input  logic                          i_valid,
  input  logic                          i_mode,
  input  logic [input_width-1:0]        i_r,
  input  logic [input_width-1:0]        i_g,
  input  logic [input_width-1:0]        i_b,
  output logic                          o_valid,
  output logic                          o_mode,
  output logic [fixed_point_length-1:0] o_y,
  output logic [fixed_point_length-1:0] o_cb,
  output logic [fixed_point_length-1:0] o_cr
);

  localparam int unsigned FPL = fixed_point_length;

  localparam logic signed [FPL-1:0] KYR  = FPL'(coef_fixed(C_YR,  frac_bits));
  localparam logic signed [FPL-1:0] KYG  = FPL'(coef_fixed(C_YG,  frac_bits));
  localparam logic signed [FPL-1:0] KYB  = FPL'(coef_fixed(C_YB,  frac_bits));
  localparam logic signed [FPL-1:0] KCBR = FPL'(coef_fixed(C_CBR, frac_bits));
  localparam logic signed [FPL-1:0] KCBG = FPL'(coef_fixed(C_CBG, frac_bits));
  localparam logic signed [FPL-1:0] KCBB = FPL'(coef_fixed(C_CBB, frac_bits));
  localparam logic signed [FPL-1:0] KCRR = FPL'(coef_fixed(C_CRR, frac_bits));
  localparam logic signed [FPL-1:0] KCRG = FPL'(coef_fixed(C_CRG, frac_bits));
  localparam logic signed [FPL-1:0] KCRB = FPL'(coef_fixed(C_CRB, frac_bits));

  // 128 in fixed point
  localparam logic [FPL-1:0] OFF = FPL'(128) << frac_bits;

  // unsigned samples zero-extended, then treated as signed operands
  logic signed [FPL-1:0] w_r, w_g, w_b;
  assign w_r = FPL'(i_r);
  assign w_g = FPL'(i_g);
  assign w_b = FPL'(i_b);

  logic           r_valid, r_mode;
  logic [FPL-1:0] r_yr, r_yg, r_yb, r_cbr, r_cbg, r_cbb, r_crr, r_crg, r_crb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_mode  <= MODE_JFIF;
    end else if (i_en) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_mode <= i_mode;
        r_yr   <= w_r * KYR;
        r_yg   <= w_g * KYG;
        r_yb   <= w_b * KYB;
        r_cbr  <= w_r * KCBR;
        r_cbg  <= w_g * KCBG;
        r_cbb  <= w_b * KCBB;
        r_crr  <= w_r * KCRR;
        r_crg  <= w_g * KCRG;
        r_crb  <= w_b * KCRB;
      end
    end
  end

  logic [FPL-1:0] w_sum_y, w_sum_cb, w_sum_cr;
  assign w_sum_y  = r_yr  + r_yg  + r_yb;
  assign w_sum_cb = r_cbr + r_cbg + r_cbb;
  assign w_sum_cr = r_crr + r_crg + r_crb;

  assign o_valid = r_valid;
  assign o_mode  = r_mode;
  assign o_y     = (r_mode == MODE_CENTRED) ? (w_sum_y - OFF) : w_sum_y;
  assign o_cb    = (r_mode == MODE_CENTRED) ? w_sum_cb : (w_sum_cb + OFF);
  assign o_cr    = (r_mode == MODE_CENTRED) ? w_sum_cr : (w_sum_cr + OFF);

endmodule

// File: rtl/rgb2ycbcr_block_stream.sv
// Streaming RGB -> YCbCr block converter.
// Accepts `lanes` pixels per beat (valid/ready), converts them in a
// two-stage pipeline and assembles a `block_pixels` block presented on a
// flat bus with its own valid/ready.
// Ports:
//   clk, rst                 clock / synchronous active-high reset
//   in_valid, in_ready       input beat handshake
//   in_mode                  block mode, sampled on a block's first beat
//   r_in/g_in/b_in           lane i at [i*input_width +: input_width]
//   out_valid, out_ready     output block handshake
//   out_mode                 mode of the presented block
//   y_all/cb_all/cr_all      pixel p at [p*fixed_point_length +: fixed_point_length]
module rgb2ycbcr_block_stream
  import rgb2ycbcr_pkg::*;
#(
  parameter int unsigned fixed_point_length = 32,
  parameter int unsigned frac_bits          = 16,
  parameter int unsigned input_width        = 8,
  parameter int unsigned lanes              = 8,
  parameter int unsigned block_pixels       = 64
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic                                       in_mode,
  input  logic [input_width*lanes-1:0]               r_in,
  input  logic [input_width*lanes-1:0]               g_in,
  input  logic [input_width*lanes-1:0]               b_in,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic                                       out_mode,
  output logic [fixed_point_length*block_pixels-1:0] y_all,
  output logic [fixed_point_length*block_pixels-1:0] cb_all,
  output logic [fixed_point_length*block_pixels-1:0] cr_all
);

  localparam int unsigned FPL = fixed_point_length;
  localparam int unsigned NB  = block_pixels / lanes;
  localparam int unsigned BW  = (NB > 1) ? $clog2(NB) : 1;

  logic             w_en, w_acc, w_s2_we, w_s2_mode, w_beat_mode;
  logic [lanes-1:0] w_lane_v, w_lane_m;
  logic [FPL-1:0]   w_y [lanes];
  logic [FPL-1:0]   w_cb[lanes];
  logic [FPL-1:0]   w_cr[lanes];

  logic [BW-1:0]    r_in_cnt, r_beat_cnt;
  logic             r_blk_mode, r_out_valid, r_out_mode;
  logic [FPL*block_pixels-1:0] r_y, r_cb, r_cr;

  // Whole pipeline stalls only while a finished block is refused.
  assign w_en     = !(r_out_valid && !out_ready);
  assign in_ready = w_en;
  assign w_acc    = in_valid && w_en;

  // First beat of a block supplies the mode; later beats reuse it.
  assign w_beat_mode = (r_in_cnt == '0) ? in_mode : r_blk_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_cnt   <= '0;
      r_blk_mode <= MODE_JFIF;
    end else if (w_acc) begin
      if (r_in_cnt == '0) begin
        r_blk_mode <= in_mode;
      end
      r_in_cnt <= (r_in_cnt == BW'(NB - 1)) ? '0 : r_in_cnt + 1'b1;
    end
  end

  for (genvar gi = 0; gi < lanes; gi++) begin : g_lane
    rgb2ycbcr_lane_pipe #(
      .fixed_point_length(fixed_point_length),
      .frac_bits         (frac_bits),
      .input_width       (input_width)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_en),
      .i_valid(in_valid),
      .i_mode (w_beat_mode),
      .i_r    (r_in[gi*input_width +: input_width]),
      .i_g    (g_in[gi*input_width +: input_width]),
      .i_b    (b_in[gi*input_width +: input_width]),
      .o_valid(w_lane_v[gi]),
      .o_mode (w_lane_m[gi]),
      .o_y    (w_y[gi]),
      .o_cb   (w_cb[gi]),
      .o_cr   (w_cr[gi])
    );
  end

  // Every lane carries the same valid/mode; reducing across them keeps all copies live.
  assign w_s2_we   = w_en && (&w_lane_v);
  assign w_s2_mode = |w_lane_m;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_mode  <= MODE_JFIF;
      r_y         <= '0;
      r_cb        <= '0;
      r_cr        <= '0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_s2_we) begin
        for (int unsigned i = 0; i < lanes; i++) begin
          r_y [(32'(r_beat_cnt) * lanes + i) * FPL +: FPL] <= w_y[i];
          r_cb[(32'(r_beat_cnt) * lanes + i) * FPL +: FPL] <= w_cb[i];
          r_cr[(32'(r_beat_cnt) * lanes + i) * FPL +: FPL] <= w_cr[i];
        end
        // completing write overrides a same-edge consume
        if (r_beat_cnt == BW'(NB - 1)) begin
          r_beat_cnt  <= '0;
          r_out_valid <= 1'b1;
          r_out_mode  <= w_s2_mode;
        end else begin
          r_beat_cnt <= r_beat_cnt + 1'b1;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_mode  = r_out_mode;
  assign y_all     = r_y;
  assign cb_all    = r_cb;
  assign cr_all    = r_cr;

endmodule

// File: tb/tb_rgb2ycbcr_block_stream.sv
module tb_rgb2ycbcr_block_stream;

  localparam int L  = 8;
  localparam int NP = 64;
  localparam int W  = 32;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, in_mode;
  logic [8*L-1:0] r_in, g_in, b_in;
  logic out_valid, out_ready, out_mode;
  logic [W*NP-1:0] y_all, cb_all, cr_all;

  always #5 clk = ~clk;

  rgb2ycbcr_block_stream #(
    .fixed_point_length(32),
    .frac_bits         (16),
    .input_width       (8),
    .lanes             (8),
    .block_pixels      (64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .r_in     (r_in),
    .g_in     (g_in),
    .b_in     (b_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_mode (out_mode),
    .y_all    (y_all),
    .cb_all   (cb_all),
    .cr_all   (cr_all)
  );

  typedef struct packed {
    logic [W*NP-1:0] y;
    logic [W*NP-1:0] cb;
    logic [W*NP-1:0] cr;
    logic            mode;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_blocks = 0;
  int n_hold   = 0;
  int rpol     = 0;   // 0: always ready, 1: random, 2: hold for hold_left presented cycles
  int hold_left = 0;
  logic [7:0] pr[NP], pg[NP], pb[NP];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lin(input int kr, input int kg, input int kb,
                                      input logic [7:0] r, input logic [7:0] g,
                                      input logic [7:0] b, input int off);
    int s;
    s = kr * int'(r) + kg * int'(g) + kb * int'(b) + off;
    return 32'(s);
  endfunction

  task automatic cmp_block(input string tag, input exp_t e);
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("%s_y_p%0d", tag, p),  y_all[p*W +: W],  e.y[p*W +: W]);
      chk($sformatf("%s_cb_p%0d", tag, p), cb_all[p*W +: W], e.cb[p*W +: W]);
      chk($sformatf("%s_cr_p%0d", tag, p), cr_all[p*W +: W], e.cr[p*W +: W]);
    end
    chk({tag, "_mode"}, 32'(out_mode), 32'(e.mode));
  endtask

  // Output monitor: consume on handshake, verify stability while held.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && out_valid) begin
      if (out_ready) begin
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          cmp_block($sformatf("blk%0d", n_blocks), e);
          n_blocks++;
        end
      end else begin
        n_hold++;
        chk("hold_in_ready", 32'(in_ready), 32'd0);
        if (sb.size() > 0) cmp_block("hold", sb[0]);
      end
    end
  end

  task automatic step_ready();
    case (rpol)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: begin
        if (hold_left > 0) begin
          out_ready = 1'b0;
          if (out_valid) hold_left--;
        end else begin
          out_ready = 1'b1;
        end
      end
    endcase
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    step_ready();
    @(posedge clk); #1;
  endtask

  task automatic drive_beat(input logic [8*L-1:0] r, input logic [8*L-1:0] g,
                            input logic [8*L-1:0] b, input logic m);
    int n = 0;
    r_in = r; g_in = g; b_in = b; in_mode = m; in_valid = 1'b1;
    step_ready();
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      @(posedge clk); #1;
      step_ready();
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 2000), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic m, input bit bub, input int nbeats);
    exp_t e;
    logic [8*L-1:0] rv, gv, bv;
    int yo, co;
    yo = m ? -8388608 : 0;
    co = m ? 0 : 8388608;
    for (int p = 0; p < NP; p++) begin
      e.y[p*W +: W]  = lin(19595, 38470, 7471, pr[p], pg[p], pb[p], yo);
      e.cb[p*W +: W] = lin(-11058, -21710, 32768, pr[p], pg[p], pb[p], co);
      e.cr[p*W +: W] = lin(32768, -27439, -5329, pr[p], pg[p], pb[p], co);
    end
    e.mode = m;
    if (nbeats == NP / L) sb.push_back(e);
    for (int bt = 0; bt < nbeats; bt++) begin
      if (bub) while ($urandom_range(0, 3) == 0) idle_cycle();
      for (int l = 0; l < L; l++) begin
        rv[l*8 +: 8] = pr[bt*L + l];
        gv[l*8 +: 8] = pg[bt*L + l];
        bv[l*8 +: 8] = pb[bt*L + l];
      end
      drive_beat(rv, gv, bv, (bt == 0) ? m : 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic fill_const(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    for (int p = 0; p < NP; p++) begin
      pr[p] = r; pg[p] = g; pb[p] = b;
    end
  endtask

  task automatic fill_rand();
    for (int p = 0; p < NP; p++) begin
      pr[p] = 8'($urandom); pg[p] = 8'($urandom); pb[p] = 8'($urandom);
    end
  endtask

  task automatic drain();
    int n = 0;
    rpol = 0;
    while (!(sb.size() == 0 && !out_valid) && n < 2000) begin
      step_ready();
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b1;
    r_in = '0; g_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_mode",  32'(out_mode),  32'd0);
    chk("rst_y_zero",    32'(|y_all),    32'd0);
    chk("rst_cbcr_zero", 32'(|cb_all | |cr_all), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // white, JFIF, with latency check
    fill_const(8'd255, 8'd255, 8'd255);
    send_block(1'b0, 1'b0, 8);
    chk("t1_lat_k", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("t1_lat_k1", 32'(out_valid), 32'd1);
    chk("t1_y0",   y_all[0 +: W],     32'h00FF0000);
    chk("t1_cb63", cb_all[63*W +: W], 32'h00800000);
    chk("t1_cr0",  cr_all[0 +: W],    32'h00800000);
    chk("t1_mode", 32'(out_mode), 32'd0);

    // white, centred
    send_block(1'b1, 1'b0, 8);
    @(posedge clk); #1;
    chk("t2_y10",  y_all[10*W +: W],  32'h007F0000);
    chk("t2_cb10", cb_all[10*W +: W], 32'h00000000);
    chk("t2_mode", 32'(out_mode), 32'd1);

    // black, centred
    fill_const(8'd0, 8'd0, 8'd0);
    send_block(1'b1, 1'b0, 8);
    @(posedge clk); #1;
    chk("t3_y0",  y_all[0 +: W],  32'hFF800000);
    chk("t3_cr0", cr_all[0 +: W], 32'h00000000);

    // single red pixel at index 5
    pr[5] = 8'd255;
    send_block(1'b0, 1'b0, 8);
    @(posedge clk); #1;
    chk("t4_y5", y_all[5*W +: W], 32'h004C3E75);
    chk("t4_y4", y_all[4*W +: W], 32'h00000000);
    chk("t4_y6", y_all[6*W +: W], 32'h00000000);
    drain();

    // back-pressure: block 1 held for 20 cycles while block 2 streams
    n_hold = 0;
    rpol = 2; hold_left = 20;
    fill_rand();
    send_block(1'b0, 1'b0, 8);
    fill_rand();
    send_block(1'b1, 1'b0, 8);
    drain();
    chk("hold_cycles", 32'(n_hold), 32'd20);

    // random bubbles and back-pressure, alternating modes
    base = n_blocks;
    rpol = 1;
    for (int b = 0; b < 100; b++) begin
      fill_rand();
      send_block(1'(b % 2), 1'b1, 8);
    end
    drain();
    chk("rand_blocks", 32'(n_blocks - base), 32'd100);

    // reset in the middle of a block
    fill_rand();
    send_block(1'b1, 1'b0, 8);
    drain();
    fill_rand();
    send_block(1'b0, 1'b0, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_mode",  32'(out_mode),  32'd0);
    chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
    chk("mid_rst_y_zero",    32'(|y_all),    32'd0);
    chk("mid_rst_cb_zero",   32'(|cb_all),   32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    fill_rand();
    send_block(1'b0, 1'b0, 8);
    chk("post_rst_lat_k", 32'(out_valid), 32'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
